// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Holds the LOAD/RUN state encoding and the default filler instruction.
package instr_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // addi x0,x0,0: returned for any word that does not hold loaded program
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h00000013;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port and one asynchronous read port.
// The contents are deliberately left out of reset so that a reset does not erase them.
module instr_mem_array #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational fetch: the core sees the instruction in the same cycle it presents the PC
  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_prog.sv
// Instruction memory that a streaming port loads with a program, then serves to the core.
// During loading, and beyond the end of the loaded program, fetches return the filler word.
module instr_mem_prog
  import instr_mem_pkg::*;
#(
  parameter int               INS_ADDRESS = 9,
  parameter int               INS_W       = 32,
  parameter logic [INS_W-1:0] NOP_WORD    = INS_W'(NOP_WORD_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INS_ADDRESS-1:0] ra,
  output logic [INS_W-1:0]       rd,
  output logic                   misalign,
  output logic                   run,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [INS_W-1:0]       ld_data,
  input  logic                   ld_last,
  input  logic                   ld_start,
  output logic [INS_ADDRESS-2:0] words_loaded
);

  localparam int IDX_W = INS_ADDRESS - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0]       WPTR_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [INS_ADDRESS-2:0] COUNT_FULL = (INS_ADDRESS-1)'(DEPTH);

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       wptr_reg, wptr_next;
  logic [INS_ADDRESS-2:0] count_reg, count_next;
  logic                   ld_ready_reg;
  logic                   accept;
  logic                   wptr_full;
  logic [IDX_W-1:0]       rd_idx;
  logic [INS_W-1:0]       mem_rdata;

  assign accept    = ld_valid && ld_ready_reg;
  assign wptr_full = (wptr_reg == WPTR_LAST);
  assign rd_idx    = ra[INS_ADDRESS-1:2];

  instr_mem_array #(
    .ADDR_W (IDX_W),
    .DATA_W (INS_W)
  ) u_array (
    .clk   (clk),
    .we    (accept),
    .waddr (wptr_reg),
    .wdata (ld_data),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  // State register; ld_ready is registered from the next state so it tracks LOAD exactly
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= LOAD;
      wptr_reg     <= '0;
      count_reg    <= '0;
      ld_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      wptr_reg     <= wptr_next;
      count_reg    <= count_next;
      ld_ready_reg <= (state_next == LOAD);
    end
  end

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    case (state_reg)
      LOAD: begin
        if (accept) begin
          // The last slot ends the load, so the pointer holds instead of wrapping
          if (!wptr_full) begin
            wptr_next = wptr_reg + 1'b1;
          end
          if (count_reg != COUNT_FULL) begin
            count_next = count_reg + 1'b1;
          end
          if (ld_last || wptr_full) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (ld_start) begin
          state_next = LOAD;
          wptr_next  = '0;
          count_next = '0;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    run          = (state_reg == RUN);
    ld_ready     = ld_ready_reg;
    words_loaded = count_reg;
    misalign     = |ra[1:0];
    rd           = NOP_WORD;
    if (state_reg == RUN && {1'b0, rd_idx} < count_reg) begin
      rd = mem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Directed bench for instr_mem_prog: a default-size instance and a 4-word instance.
// Fetch checks are table driven; load/reload/reset corner cases are hand sequenced.
module tb_instr_mem_prog;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;

  logic [8:0]  ra;
  logic [31:0] rd;
  logic        misalign, run, ld_valid, ld_ready, ld_last, ld_start;
  logic [31:0] ld_data;
  logic [7:0]  words_loaded;

  logic [3:0]  s_ra;
  logic [31:0] s_rd;
  logic        s_misalign, s_run, s_ld_valid, s_ld_ready, s_ld_last, s_ld_start;
  logic [31:0] s_ld_data;
  logic [2:0]  s_words_loaded;

  int checks;
  int errors;

  typedef struct {
    logic [8:0]  ra;
    logic [31:0] rd;
    logic        mis;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] b4 [4];
  logic [31:0] p5 [5];

  instr_mem_prog dut (
    .clk          (clk),
    .reset        (reset),
    .ra           (ra),
    .rd           (rd),
    .misalign     (misalign),
    .run          (run),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_start     (ld_start),
    .words_loaded (words_loaded)
  );

  instr_mem_prog #(.INS_ADDRESS(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .ra           (s_ra),
    .rd           (s_rd),
    .misalign     (s_misalign),
    .run          (s_run),
    .ld_valid     (s_ld_valid),
    .ld_ready     (s_ld_ready),
    .ld_data      (s_ld_data),
    .ld_last      (s_ld_last),
    .ld_start     (s_ld_start),
    .words_loaded (s_words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [8:0] a, input logic [31:0] exp);
    ra = a;
    #1;
    check(name, rd, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    ra = '0; ld_valid = 0; ld_data = '0; ld_last = 0; ld_start = 0;
    s_ra = '0; s_ld_valid = 0; s_ld_data = '0; s_ld_last = 0; s_ld_start = 0;
    b4[0] = 32'h11111111; b4[1] = 32'h22222222; b4[2] = 32'h33333333; b4[3] = 32'h44444444;
    p5[0] = 32'hA0000001; p5[1] = 32'hA0000002; p5[2] = 32'hA0000003;
    p5[3] = 32'hA0000004; p5[4] = 32'hA0000005;

    vecs[0] = '{ra: 9'd0,   rd: 32'h00800093, mis: 1'b0};
    vecs[1] = '{ra: 9'd4,   rd: 32'h00400113, mis: 1'b0};
    vecs[2] = '{ra: 9'd8,   rd: 32'h0020E1B3, mis: 1'b0};
    vecs[3] = '{ra: 9'd12,  rd: NOP,          mis: 1'b0};
    vecs[4] = '{ra: 9'h5,   rd: 32'h00400113, mis: 1'b1};
    vecs[5] = '{ra: 9'd2,   rd: 32'h00800093, mis: 1'b1};
    vecs[6] = '{ra: 9'd11,  rd: 32'h0020E1B3, mis: 1'b1};
    vecs[7] = '{ra: 9'd508, rd: NOP,          mis: 1'b0};
    vecs[8] = '{ra: 9'd256, rd: NOP,          mis: 1'b0};

    // Reset state
    tick();
    tick();
    check("reset_run", 32'(run), 32'd0);
    check("reset_ld_ready", 32'(ld_ready), 32'd1);
    check("reset_words", 32'(words_loaded), 32'd0);
    fetch("reset_rd", 9'd0, NOP);
    reset = 1'b1;
    tick();

    // 4-word instance fills without ld_last
    for (int i = 0; i < 3; i++) begin
      s_ld_valid = 1'b1;
      s_ld_data  = b4[i];
      tick();
    end
    check("d4_run_after3", 32'(s_run), 32'd0);
    check("d4_words_after3", 32'(s_words_loaded), 32'd3);
    s_ld_data = b4[3];
    tick();
    check("d4_run_after4", 32'(s_run), 32'd1);
    check("d4_words_after4", 32'(s_words_loaded), 32'd4);
    check("d4_ready_after4", 32'(s_ld_ready), 32'd0);
    s_ld_data = 32'hBADBAD00;
    tick();
    tick();
    check("d4_words_5th", 32'(s_words_loaded), 32'd4);
    for (int i = 0; i < 4; i++) begin
      s_ra = 4'(i * 4);
      #1;
      check($sformatf("d4_rd_%0d", i), s_rd, b4[i]);
    end
    s_ld_valid = 1'b0;

    // Three-beat program
    beat(32'h00800093, 1'b0);
    beat(32'h00400113, 1'b0);
    check("load_run_before_last", 32'(run), 32'd0);
    fetch("load_rd_nop", 9'd0, NOP);
    beat(32'h0020E1B3, 1'b1);
    check("load_run", 32'(run), 32'd1);
    check("load_words", 32'(words_loaded), 32'd3);
    check("load_ready", 32'(ld_ready), 32'd0);

    for (int i = 0; i < 9; i++) begin
      ra = vecs[i].ra;
      #1;
      check($sformatf("vec%0d_rd", i), rd, vecs[i].rd);
      check($sformatf("vec%0d_mis", i), 32'(misalign), 32'(vecs[i].mis));
    end

    // ld_valid held while not ready, then ld_start reopens loading
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD0001;
    tick();
    tick();
    check("hold_words", 32'(words_loaded), 32'd3);
    fetch("hold_rd0", 9'd0, 32'h00800093);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("start_run", 32'(run), 32'd0);
    check("start_ready", 32'(ld_ready), 32'd1);
    check("start_words", 32'(words_loaded), 32'd0);
    fetch("start_rd0", 9'd0, NOP);
    fetch("start_rd4", 9'd4, NOP);
    tick();
    check("reload_words1", 32'(words_loaded), 32'd1);
    fetch("reload_rd_nop", 9'd0, NOP);
    // ld_start during LOAD is ignored; the beat still lands at the next slot
    ld_data  = 32'hBEEF0002;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("ignore_start_words", 32'(words_loaded), 32'd2);
    check("ignore_start_run", 32'(run), 32'd0);
    ld_data = 32'hCAFE0003;
    ld_last = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("reload_run", 32'(run), 32'd1);
    check("reload_words", 32'(words_loaded), 32'd3);
    fetch("reload_rd0", 9'd0, 32'hDEAD0001);
    fetch("reload_rd4", 9'd4, 32'hBEEF0002);
    fetch("reload_rd8", 9'd8, 32'hCAFE0003);

    // Reset in the middle of a reload
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    beat(p5[0], 1'b0);
    beat(p5[1], 1'b0);
    reset = 1'b0;
    tick();
    check("midrst_run", 32'(run), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_ready", 32'(ld_ready), 32'd1);
    fetch("midrst_rd", 9'd0, NOP);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat(p5[i], (i == 4));
    end
    check("p5_run", 32'(run), 32'd1);
    check("p5_words", 32'(words_loaded), 32'd5);
    for (int i = 0; i < 5; i++) begin
      fetch($sformatf("p5_rd%0d", i), 9'(i * 4), p5[i]);
    end
    fetch("p5_rd_past", 9'd20, NOP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_prog.md
INSTR_MEM_PROG -- requirements
Module: instr_mem_prog

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 9, byte-address width; depth = 2**(INS_ADDRESS-2) words.
REQ-002 SHALL have parameter INS_W, default 32, instruction word width.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013 (addi x0,x0,0), filler word.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 ra  input  INS_ADDRESS  fetch byte address from PC.
REQ-007 rd  output  INS_W  fetched instruction, combinational from ra and state.
REQ-008 misalign  output  1  high when ra[1:0] != 0.
REQ-009 run  output  1  high in RUN state; core may advance PC only when high.
REQ-010 ld_valid  input  1  load beat present.
REQ-011 ld_ready  output  1  load port accepts beat; registered, equals state==LOAD.
REQ-012 ld_data  input  INS_W  instruction word to load.
REQ-013 ld_last  input  1  marks final beat of program.
REQ-014 ld_start  input  1  single-cycle request to reload program.
REQ-015 words_loaded  output  INS_ADDRESS-1  count of valid program words.

Function
REQ-016 SHALL implement two states: LOAD, RUN.
REQ-017 Beat accepted when ld_valid && ld_ready; writes ld_data to mem[wptr], wptr+1, words_loaded+1 next cycle.
REQ-018 LOAD->RUN on accepted beat with ld_last=1, or accepted beat at wptr = depth-1 (full), whichever first; no wrap of wptr.
REQ-019 RUN->LOAD on ld_start=1; next cycle wptr=0, words_loaded=0; memory contents untouched.
REQ-020 ld_start in LOAD state SHALL be ignored.
REQ-021 ld_valid with ld_ready=0 SHALL not write; source holds beat until accepted.
REQ-022 In LOAD, rd SHALL equal NOP_WORD for every ra.
REQ-023 In RUN, rd = mem[ra[INS_ADDRESS-1:2]] when that index < words_loaded, else NOP_WORD.
REQ-024 Read is zero-latency combinational; write-to-read latency is one cycle.
REQ-025 misalign is purely combinational; rd still uses ra[INS_ADDRESS-1:2] when misaligned.
REQ-026 words_loaded saturates at depth; width holds value depth exactly.

Reset
REQ-027 On clk edge with reset=0: state=LOAD, wptr=0, words_loaded=0, ld_ready=1 next cycle, run=0.
REQ-028 Reset mid-load SHALL discard progress; rd reads NOP_WORD until reload completes.
REQ-029 Memory array SHALL not be reset.

Structure
REQ-030 Package instr_mem_pkg SHALL hold state enum {LOAD, RUN} and NOP_WORD default constant.
REQ-031 Storage SHALL be a sub-module instr_mem_array (1 write port, 1 async read port, no reset).
REQ-032 FSM, pointer, count and rd masking SHALL live in instr_mem_prog.

Verification
REQ-033 Reset, load 3 beats 32'h00800093, 32'h00400113, 32'h0020E1B3 (last on 3rd) -> run=1 next cycle, words_loaded=3, ra=0/4/8 return those words, ra=12 returns 32'h00000013.
REQ-034 ld_valid held high with ld_ready toggling via ld_start in RUN -> no write while ld_ready=0; after ld_start wptr=0, words_loaded=0, rd=NOP for all ra until new ld_last.
REQ-035 INS_ADDRESS=4 (depth 4), 4 beats no ld_last -> RUN after 4th, words_loaded=4, 5th ld_valid not accepted.
REQ-036 ra=32'h5 in RUN -> misalign=1, rd=mem[1].
REQ-037 reset low after 2 of 5 beats -> run=0, words_loaded=0, rd=NOP; full 5-beat reload then reads correct.
REQ-038 ld_start asserted during LOAD with beat -> beat written normally, wptr not cleared.
